// File: rtl/game_pkg.sv
// Shared fighter-state, stun, round and winner codes for the combat referee.
package game_pkg;

  localparam int PLAYER_WIDTH = 64;

  // Controller state encoding; codes 11..15 are unused and never attack or block.
  localparam logic [3:0] S_IDLE             = 4'd0;
  localparam logic [3:0] S_FORWARD          = 4'd1;
  localparam logic [3:0] S_BACKWARD         = 4'd2;
  localparam logic [3:0] S_IATTACK_START    = 4'd3;
  localparam logic [3:0] S_IATTACK_ACTIVE   = 4'd4;
  localparam logic [3:0] S_IATTACK_RECOVERY = 4'd5;
  localparam logic [3:0] S_DATTACK_START    = 4'd6;
  localparam logic [3:0] S_DATTACK_ACTIVE   = 4'd7;
  localparam logic [3:0] S_DATTACK_RECOVERY = 4'd8;
  localparam logic [3:0] S_HITSTUN          = 4'd9;
  localparam logic [3:0] S_BLOCKSTUN        = 4'd10;

  localparam logic [1:0] STUN_NONE  = 2'b00;
  localparam logic [1:0] STUN_HIT   = 2'b01;
  localparam logic [1:0] STUN_BLOCK = 2'b10;

  typedef enum logic [1:0] {
    RS_WAIT  = 2'b00,
    RS_FIGHT = 2'b01,
    RS_KO    = 2'b10
  } round_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [2:0] sat_sub(input logic [2:0] a, input logic [2:0] b);
    return (a > b) ? (a - b) : 3'd0;
  endfunction

endpackage

// File: rtl/hit_resolver.sv
// One attack direction: decides whether the attacker's active frame connects,
// whether it is blocked, and how much damage it carries. Lands once per active window.
module hit_resolver
  import game_pkg::*;
#(
  parameter int I_REACH  = 20,
  parameter int D_REACH  = 32,
  parameter int I_DAMAGE = 1,
  parameter int D_DAMAGE = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [3:0] atk_state_i,
  input  logic [9:0] left_x_i,
  input  logic [9:0] right_x_i,
  input  logic [3:0] def_state_i,
  output logic       valid_o,
  output logic       is_block_o,
  output logic [2:0] damage_o
);

  logic        active;
  logic [10:0] reach;
  logic        overlap;
  logic        hit_done_q, hit_done_d;

  always_comb begin
    active   = 1'b0;
    reach    = 11'd0;
    damage_o = 3'd0;
    case (atk_state_i)
      S_IATTACK_ACTIVE: begin
        active   = 1'b1;
        reach    = 11'(I_REACH);
        damage_o = 3'(I_DAMAGE);
      end
      S_DATTACK_ACTIVE: begin
        active   = 1'b1;
        reach    = 11'(D_REACH);
        damage_o = 3'(D_DAMAGE);
      end
      default: ;
    endcase
  end

  // 11-bit sum so a front edge past x=1023 still counts as overlapping.
  assign overlap    = {1'b0, right_x_i} <= ({1'b0, left_x_i} + 11'(PLAYER_WIDTH) + reach);
  assign valid_o    = active & overlap & ~hit_done_q & enable_i;
  assign is_block_o = (def_state_i == S_BACKWARD);
  assign hit_done_d = active & (hit_done_q | valid_o);

  always_ff @(posedge clk_i) begin
    if (reset_i) hit_done_q <= 1'b0;
    else         hit_done_q <= hit_done_d;
  end

endmodule

// File: rtl/combat_arbiter.sv
// Frame-rate referee: resolves both attack directions, drives one-frame stun pulses,
// tracks health and runs the WAIT/FIGHT/KO round machine. All outputs registered.
module combat_arbiter
  import game_pkg::*;
#(
  parameter int I_REACH        = 20,
  parameter int D_REACH        = 32,
  parameter int MAX_HEALTH     = 3,
  parameter int I_DAMAGE       = 1,
  parameter int D_DAMAGE       = 2,
  parameter int KO_HOLD_FRAMES = 120
) (
  input  logic       logic_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] player1_pos_x,
  input  logic [3:0] player1_state,
  input  logic [9:0] player2_pos_x,
  input  logic [3:0] player2_state,
  output logic [1:0] stunmode1,
  output logic [1:0] stunmode2,
  output logic [2:0] p1_health,
  output logic [2:0] p2_health,
  output logic [1:0] round_state,
  output logic [1:0] winner,
  output logic       freeze
);

  localparam int KW = $clog2(KO_HOLD_FRAMES + 1);

  round_e          state_q, state_d;
  logic [1:0]      stun1_q, stun1_d, stun2_q, stun2_d;
  logic [2:0]      h1_q, h1_d, h2_q, h2_d;
  logic [1:0]      win_q, win_d;
  logic            freeze_q, freeze_d;
  logic [KW-1:0]   cnt_q, cnt_d;

  logic            fight;
  logic            v12, blk12, v21, blk21;
  logic [2:0]      dmg12, dmg21;

  assign fight = (state_q == RS_FIGHT);

  // P1 faces right and P2 left, so both directions share the same gap test.
  hit_resolver #(.I_REACH(I_REACH), .D_REACH(D_REACH), .I_DAMAGE(I_DAMAGE), .D_DAMAGE(D_DAMAGE)) u_p1_hits_p2 (
    .clk_i(logic_clk), .reset_i(reset), .enable_i(fight),
    .atk_state_i(player1_state), .left_x_i(player1_pos_x), .right_x_i(player2_pos_x),
    .def_state_i(player2_state), .valid_o(v12), .is_block_o(blk12), .damage_o(dmg12)
  );

  hit_resolver #(.I_REACH(I_REACH), .D_REACH(D_REACH), .I_DAMAGE(I_DAMAGE), .D_DAMAGE(D_DAMAGE)) u_p2_hits_p1 (
    .clk_i(logic_clk), .reset_i(reset), .enable_i(fight),
    .atk_state_i(player2_state), .left_x_i(player1_pos_x), .right_x_i(player2_pos_x),
    .def_state_i(player1_state), .valid_o(v21), .is_block_o(blk21), .damage_o(dmg21)
  );

  always_comb begin
    state_d = state_q;
    stun1_d = STUN_NONE;
    stun2_d = STUN_NONE;
    h1_d    = h1_q;
    h2_d    = h2_q;
    win_d   = win_q;
    cnt_d   = cnt_q;

    // Swings are only valid in FIGHT, so KO automatically keeps stun at none.
    if (v12) begin
      stun2_d = blk12 ? STUN_BLOCK : STUN_HIT;
      if (!blk12) h2_d = sat_sub(h2_q, dmg12);
    end
    if (v21) begin
      stun1_d = blk21 ? STUN_BLOCK : STUN_HIT;
      if (!blk21) h1_d = sat_sub(h1_q, dmg21);
    end

    case (state_q)
      RS_WAIT: begin
        if (start) begin
          state_d = RS_FIGHT;
          h1_d    = 3'(MAX_HEALTH);
          h2_d    = 3'(MAX_HEALTH);
          win_d   = WIN_NONE;
        end
      end
      RS_FIGHT: begin
        if (h1_d == 3'd0 || h2_d == 3'd0) begin
          state_d = RS_KO;
          cnt_d   = '0;
          if (h1_d == 3'd0 && h2_d == 3'd0) win_d = WIN_DRAW;
          else if (h2_d == 3'd0)            win_d = WIN_P1;
          else                              win_d = WIN_P2;
        end
      end
      RS_KO: begin
        if (cnt_q == KW'(KO_HOLD_FRAMES - 1)) state_d = RS_WAIT;
        else                                  cnt_d   = cnt_q + KW'(1);
      end
      default: state_d = RS_WAIT;
    endcase

    freeze_d = (state_d != RS_FIGHT);
  end

  always_ff @(posedge logic_clk) begin
    if (reset) begin
      state_q  <= RS_WAIT;
      stun1_q  <= STUN_NONE;
      stun2_q  <= STUN_NONE;
      h1_q     <= 3'(MAX_HEALTH);
      h2_q     <= 3'(MAX_HEALTH);
      win_q    <= WIN_NONE;
      freeze_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stun1_q  <= stun1_d;
      stun2_q  <= stun2_d;
      h1_q     <= h1_d;
      h2_q     <= h2_d;
      win_q    <= win_d;
      freeze_q <= freeze_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stunmode1   = stun1_q;
  assign stunmode2   = stun2_q;
  assign p1_health   = h1_q;
  assign p2_health   = h2_q;
  assign round_state = state_q;
  assign winner      = win_q;
  assign freeze      = freeze_q;

endmodule

// File: tb/tb_combat_arbiter.sv
// Bench for combat_arbiter: directed vector table, KO/reset sequences, then random frames vs a model.
module tb_combat_arbiter;
  import game_pkg::*;

  logic       logic_clk = 1'b0;
  logic       reset = 1'b1, start = 1'b0;
  logic [9:0] player1_pos_x = 10'd100, player2_pos_x = 10'd180;
  logic [3:0] player1_state = S_IDLE, player2_state = S_IDLE;
  logic [1:0] stunmode1, stunmode2, round_state, winner;
  logic [2:0] p1_health, p2_health;
  logic       freeze;

  combat_arbiter dut (
    .logic_clk(logic_clk), .reset(reset), .start(start),
    .player1_pos_x(player1_pos_x), .player1_state(player1_state),
    .player2_pos_x(player2_pos_x), .player2_state(player2_state),
    .stunmode1(stunmode1), .stunmode2(stunmode2),
    .p1_health(p1_health), .p2_health(p2_health),
    .round_state(round_state), .winner(winner), .freeze(freeze)
  );

  always #5 logic_clk = ~logic_clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       rst, st;
    logic [9:0] p1x;
    logic [3:0] p1s;
    logic [9:0] p2x;
    logic [3:0] p2s;
    logic [1:0] s1, s2;
    logic [2:0] h1, h2;
    logic [1:0] rs, win;
    logic       frz;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, int p1x, logic [3:0] p1s, int p2x, logic [3:0] p2s,
                              int s1, int s2, int h1, int h2, int rs, int win, int frz);
    vec_t v;
    v.rst = rst; v.st = st; v.p1x = 10'(p1x); v.p1s = p1s; v.p2x = 10'(p2x); v.p2s = p2s;
    v.s1 = 2'(s1); v.s2 = 2'(s2); v.h1 = 3'(h1); v.h2 = 3'(h2);
    v.rs = 2'(rs); v.win = 2'(win); v.frz = frz[0];
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int s1, input int s2, input int h1, input int h2,
                         input int rs, input int win, input int frz);
    chk({tag, ".stunmode1"}, 32'(stunmode1), 32'(s1));
    chk({tag, ".stunmode2"}, 32'(stunmode2), 32'(s2));
    chk({tag, ".p1_health"}, 32'(p1_health), 32'(h1));
    chk({tag, ".p2_health"}, 32'(p2_health), 32'(h2));
    chk({tag, ".round_state"}, 32'(round_state), 32'(rs));
    chk({tag, ".winner"}, 32'(winner), 32'(win));
    chk({tag, ".freeze"}, 32'(freeze), 32'(frz));
  endtask

  // Drive one frame's inputs, let the edge happen, then settle before sampling.
  task automatic apply(input logic rst, input logic st, input logic [9:0] p1x, input logic [3:0] p1s,
                       input logic [9:0] p2x, input logic [3:0] p2s);
    reset = rst; start = st;
    player1_pos_x = p1x; player1_state = p1s;
    player2_pos_x = p2x; player2_state = p2s;
    @(posedge logic_clk);
    #1;
  endtask

  // Reference model: round phase 0/1/2, health as integers, one "already landed" flag per attacker.
  int m_phase, m_h1, m_h2, m_win, m_frames, m_s1, m_s2;
  bit m_landed1, m_landed2;

  function automatic bit is_swing(logic [3:0] s);
    return (s == S_IATTACK_ACTIVE) || (s == S_DATTACK_ACTIVE);
  endfunction

  function automatic int reach_of(logic [3:0] s);
    return (s == S_IATTACK_ACTIVE) ? 20 : 32;
  endfunction

  function automatic int dmg_of(logic [3:0] s);
    return (s == S_IATTACK_ACTIVE) ? 1 : 2;
  endfunction

  task automatic model_step(input logic rst, input logic st, input int p1x, input logic [3:0] p1s,
                            input int p2x, input logic [3:0] p2s);
    bit  lands1, lands2;
    int  n1, n2;
    if (rst) begin
      m_phase = 0; m_h1 = 3; m_h2 = 3; m_win = 0; m_frames = 0;
      m_s1 = 0; m_s2 = 0; m_landed1 = 0; m_landed2 = 0;
      return;
    end
    lands1 = is_swing(p1s) && (p2x <= p1x + 64 + reach_of(p1s)) && !m_landed1 && m_phase == 1;
    lands2 = is_swing(p2s) && (p2x <= p1x + 64 + reach_of(p2s)) && !m_landed2 && m_phase == 1;
    m_landed1 = is_swing(p1s) && (m_landed1 || lands1);
    m_landed2 = is_swing(p2s) && (m_landed2 || lands2);
    n1 = m_h1; n2 = m_h2; m_s1 = 0; m_s2 = 0;
    if (lands1) begin
      if (p2s == S_BACKWARD) m_s2 = 2;
      else begin m_s2 = 1; n2 = (m_h2 - dmg_of(p1s) < 0) ? 0 : m_h2 - dmg_of(p1s); end
    end
    if (lands2) begin
      if (p1s == S_BACKWARD) m_s1 = 2;
      else begin m_s1 = 1; n1 = (m_h1 - dmg_of(p2s) < 0) ? 0 : m_h1 - dmg_of(p2s); end
    end
    m_h1 = n1; m_h2 = n2;
    if (m_phase == 0) begin
      if (st) begin m_phase = 1; m_h1 = 3; m_h2 = 3; m_win = 0; end
    end else if (m_phase == 1) begin
      if (m_h1 == 0 || m_h2 == 0) begin
        m_phase = 2; m_frames = 1;
        m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h2 == 0 ? 1 : 2);
      end
    end else begin
      if (m_frames == 120) m_phase = 0;
      else m_frames++;
    end
  endtask

  vec_t tbl[18];

  initial begin
    int ko_edges;
    logic [9:0]  rx1, rx2;
    logic [3:0]  rs1, rs2;
    logic        rrst, rst_st;

    tbl[0]  = mk(1, 0, 100, S_IDLE, 180, S_IDLE,                0, 0, 3, 3, 0, 0, 1);
    tbl[1]  = mk(0, 1, 100, S_IDLE, 180, S_IDLE,                0, 0, 3, 3, 1, 0, 0);
    tbl[2]  = mk(0, 0, 100, S_IATTACK_ACTIVE, 180, S_IDLE,      0, 1, 3, 2, 1, 0, 0);
    tbl[3]  = mk(0, 0, 100, S_IATTACK_ACTIVE, 180, S_IDLE,      0, 0, 3, 2, 1, 0, 0);
    tbl[4]  = mk(0, 0, 100, S_IDLE, 180, S_IDLE,                0, 0, 3, 2, 1, 0, 0);
    tbl[5]  = mk(0, 0, 100, S_IATTACK_ACTIVE, 190, S_IDLE,      0, 0, 3, 2, 1, 0, 0);
    tbl[6]  = mk(0, 0, 100, S_IDLE, 180, S_BACKWARD,            0, 0, 3, 2, 1, 0, 0);
    tbl[7]  = mk(0, 0, 100, S_IATTACK_ACTIVE, 180, S_BACKWARD,  0, 2, 3, 2, 1, 0, 0);
    tbl[8]  = mk(0, 1, 100, S_IDLE, 180, S_IDLE,                0, 0, 3, 2, 1, 0, 0);
    tbl[9]  = mk(1, 0, 100, S_IDLE, 180, S_IDLE,                0, 0, 3, 3, 0, 0, 1);
    tbl[10] = mk(0, 1, 100, S_IDLE, 190, S_IDLE,                0, 0, 3, 3, 1, 0, 0);
    tbl[11] = mk(0, 0, 100, S_DATTACK_ACTIVE, 190, S_IDLE,      0, 1, 3, 1, 1, 0, 0);
    tbl[12] = mk(0, 0, 100, S_DATTACK_ACTIVE, 190, S_IDLE,      0, 0, 3, 1, 1, 0, 0);
    tbl[13] = mk(0, 0, 100, 4'd15, 170, S_IDLE,                 0, 0, 3, 1, 1, 0, 0);
    tbl[14] = mk(0, 0, 100, S_IDLE, 170, S_DATTACK_ACTIVE,      1, 0, 1, 1, 1, 0, 0);
    tbl[15] = mk(0, 0, 100, S_IDLE, 170, S_IDLE,                0, 0, 1, 1, 1, 0, 0);
    tbl[16] = mk(0, 0, 100, S_IATTACK_ACTIVE, 170, S_IATTACK_ACTIVE, 1, 1, 0, 0, 2, 3, 1);
    tbl[17] = mk(0, 1, 100, S_IDLE, 170, S_IDLE,                0, 0, 0, 0, 2, 3, 1);

    apply(1, 0, 10'd100, S_IDLE, 10'd180, S_IDLE);
    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].rst, tbl[i].st, tbl[i].p1x, tbl[i].p1s, tbl[i].p2x, tbl[i].p2s);
      chk_all($sformatf("vec%0d", i), tbl[i].s1, tbl[i].s2, tbl[i].h1, tbl[i].h2,
              tbl[i].rs, tbl[i].win, tbl[i].frz);
    end

    // KO hold: KO was entered at vec16, vec17 was the first hold frame.
    ko_edges = 1;
    while (round_state == RS_KO && ko_edges < 200) begin
      apply(0, 0, 10'd100, S_IDLE, 10'd170, S_IDLE);
      ko_edges++;
    end
    chk("ko_hold_len", 32'(ko_edges), 32'd120);
    chk_all("ko_to_wait", 0, 0, 0, 0, 0, 3, 1);

    apply(0, 1, 10'd100, S_IDLE, 10'd180, S_IDLE);
    chk_all("restart", 0, 0, 3, 3, 1, 0, 0);
    apply(1, 0, 10'd100, S_IATTACK_ACTIVE, 10'd180, S_IDLE);
    chk_all("reset_cancels_stun", 0, 0, 3, 3, 0, 0, 1);

    apply(0, 1, 10'd100, S_IDLE, 10'd190, S_IDLE);
    apply(0, 0, 10'd100, S_DATTACK_ACTIVE, 10'd190, S_IDLE);
    chk_all("p2_dhit1", 0, 1, 3, 1, 1, 0, 0);
    apply(0, 0, 10'd100, S_IDLE, 10'd190, S_IDLE);
    apply(0, 0, 10'd100, S_DATTACK_ACTIVE, 10'd190, S_IDLE);
    chk_all("p1_wins", 0, 1, 3, 0, 2, 1, 1);
    for (int i = 1; i < 60; i++) apply(0, 0, 10'd100, S_IDLE, 10'd190, S_IDLE);
    chk_all("ko_frame59", 0, 0, 3, 0, 2, 1, 1);
    apply(1, 0, 10'd100, S_IDLE, 10'd190, S_IDLE);
    chk_all("reset_in_ko", 0, 0, 3, 3, 0, 0, 1);

    // Random frames against the reference model.
    apply(1, 0, 10'd100, S_IDLE, 10'd180, S_IDLE);
    model_step(1, 0, 100, S_IDLE, 180, S_IDLE);
    for (int i = 0; i < 3000; i++) begin
      rrst   = ($urandom_range(0, 299) == 0);
      rst_st = ($urandom_range(0, 7) == 0);
      rx1    = 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) rx2 = 10'((int'(rx1) + $urandom_range(40, 110) > 1023) ? 1023 : int'(rx1) + $urandom_range(40, 110));
      else                           rx2 = 10'($urandom_range(0, 1023));
      rs1 = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? S_IATTACK_ACTIVE : S_DATTACK_ACTIVE)
                                        : 4'($urandom_range(0, 15));
      rs2 = ($urandom_range(0, 1) == 1) ? (($urandom_range(0, 1) == 1) ? S_IATTACK_ACTIVE : S_DATTACK_ACTIVE)
                                        : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) rs2 = S_BACKWARD;
      apply(rrst, rst_st, rx1, rs1, rx2, rs2);
      model_step(rrst, rst_st, int'(rx1), rs1, int'(rx2), rs2);
      chk_all($sformatf("rand%0d", i), m_s1, m_s2, m_h1, m_h2, m_phase, m_win, (m_phase != 1) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
